f16_fmac_accum_seq: RTL and testbench

// - Sequencer that sits directly upstream of the combinational FP16 FMAC core.
// - Streams a vector of (x,y) operand pairs into the core and feeds the core result back as z.
// - Computes acc = init + sum(x_i*y_i) over len pairs (dot product / MAC reduction).
// - Presents the final sum on a valid/ready output port.
// - The core is external and attaches through the core_* ports; this block only sequences and holds state.

---
 rtl/f16_fmac_pkg.sv | 19 +
 rtl/f16_fmac_accum_seq.sv | 120 ++++++++++++
 tb/tb_f16_fmac_accum_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/f16_fmac_pkg.sv
// Shared definitions for the FP16 FMAC accumulation sequencer.
//   state_e      : sequencer FSM encoding (IDLE, LOAD, MAC, DONE)
//   F16_ONE      : FP16 constant 1.0
//   F16_SAT      : positive saturated value produced by the core
//   F16_EXP_MAX  : all-ones exponent field, marks a saturated core result
package f16_fmac_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StMac  = 2'd2,
      StDone = 2'd3
   } state_e;

   localparam logic [15:0] F16_ONE     = 16'h3C00;
   localparam logic [15:0] F16_SAT     = 16'h7FFF;
   localparam logic [4:0]  F16_EXP_MAX = 5'h1F;

endpackage

// File: rtl/f16_fmac_accum_seq.sv
// Sequencer feeding an external combinational FP16 FMAC core. It streams (x,y) pairs
// into the core, feeds the core result back as z, and computes
//   acc = init + sum(x_i * y_i) over len pairs.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, len, init      begin a run (sampled only when idle), pair count, initial acc
//   in_valid/in_ready     operand pair handshake, operands in_x / in_y
//   core_x/y/z            registered operands to the core, core_result back from it
//   out_valid/out_ready   result handshake, result out_acc, sticky saturation flag out_ovf
//   busy, count           run in progress, pairs accumulated so far
module f16_fmac_accum_seq
   import f16_fmac_pkg::*;
#(
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [15:0]      init,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_x,
   input  logic [15:0]      in_y,
   output logic [15:0]      core_x,
   output logic [15:0]      core_y,
   output logic [15:0]      core_z,
   input  logic [15:0]      core_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_acc,
   output logic             out_ovf,
   output logic             busy,
   output logic [LEN_W-1:0] count
);

   state_e           state_q, state_d;
   logic [15:0]      acc_q, acc_d;
   logic [15:0]      x_q, x_d;
   logic [15:0]      y_q, y_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] count_inc;
   logic             ovf_q, ovf_d;

   assign count_inc = count_q + LEN_W'(1);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      len_d   = len_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d   = init;
               len_d   = len;
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = (len == '0) ? StDone : StLoad;
            end
         end
         StLoad: begin
            if (in_valid) begin
               x_d     = in_x;
               y_d     = in_y;
               state_d = StMac;
            end
         end
         StMac: begin
            // Core output reflects the operands registered in LOAD.
            acc_d   = core_result;
            count_d = count_inc;
            ovf_d   = ovf_q | (core_result[14:10] == F16_EXP_MAX);
            state_d = (count_inc == len_q) ? StDone : StLoad;
         end
         StDone: begin
            // A start arriving together with out_ready is dropped: we only return to idle.
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         len_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         len_q   <= len_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == StLoad);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign core_x    = x_q;
   assign core_y    = y_q;
   assign core_z    = acc_q;
   assign out_acc   = acc_q;
   assign out_ovf   = ovf_q;
   assign count     = count_q;

endmodule

// File: tb/tb_f16_fmac_accum_seq.sv
// Bench for f16_fmac_accum_seq with a behavioural FP16 FMAC core attached.
module tb_f16_fmac_accum_seq;

   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic [15:0]      init = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_x = '0;
   logic [15:0]      in_y = '0;
   logic [15:0]      core_x, core_y, core_z, core_result;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [15:0]      out_acc;
   logic             out_ovf;
   logic             busy;
   logic [LEN_W-1:0] count;

   int n_pass = 0;
   int n_total = 0;

   logic [15:0] vx [256];
   logic [15:0] vy [256];

   always #5 clk = ~clk;

   f16_fmac_accum_seq #(.LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .init(init),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
      .core_x(core_x), .core_y(core_y), .core_z(core_z), .core_result(core_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf),
      .busy(busy), .count(count)
   );

   // ---------------- behavioural FP16 core (real arithmetic, saturating) ----------------
   function automatic real pow2(input int n);
      real r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real f2r(input logic [15:0] h);
      int  e = int'(h[14:10]);
      int  m = int'(h[9:0]);
      real v;
      if (e == 0) v = m * pow2(-24);
      else v = (1.0 + m / 1024.0) * pow2(e - 15);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] r2f(input real v);
      logic s = (v < 0.0);
      real  a = s ? -v : v;
      int   e, m;
      if (a >= 65520.0) return s ? 16'hFFFF : 16'h7FFF;
      if (a < pow2(-14)) begin
         m = $rtoi(a * pow2(24) + 0.5);
         return {s, 15'(m)};
      end
      e = -14;
      while (a >= pow2(e + 1)) e++;
      m = $rtoi(a / pow2(e) * 1024.0 + 0.5) - 1024;
      if (m == 1024) begin m = 0; e++; end
      if (e > 15) return s ? 16'hFFFF : 16'h7FFF;
      return {s, 5'(e + 15), 10'(m)};
   endfunction

   function automatic logic [15:0] core_fn(input logic [15:0] x, y, z);
      return r2f(f2r(x) * f2r(y) + f2r(z));
   endfunction

   always_comb core_result = core_fn(core_x, core_y, core_z);

   // Reference: fold the core over the vector, tracking any saturated partial sum.
   task automatic model(input int n, input logic [15:0] init_v,
                        output logic [15:0] acc, output logic ovf);
      acc = init_v;
      ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         acc = core_fn(vx[i], vy[i], acc);
         if (acc[14:10] == 5'h1F) ovf = 1'b1;
      end
   endtask

   function automatic logic [15:0] rand_f16();
      return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 18)), 10'($urandom)};
   endfunction

   // Drives one run; all driving and sampling happens on the falling edge.
   // lat counts cycles from the start cycle to the first cycle with out_valid.
   task automatic do_run(input int n, input logic [15:0] init_v, input bit gaps, input int hold,
                         output logic [15:0] acc, output logic ovf, output logic [LEN_W-1:0] cnt,
                         output int lat, output bit timeout, output bit saw_ready,
                         output bit stable, output bit dropped_ok, output logic [15:0] post_acc);
      int cyc = 0;
      int idx = 0;
      bit prev_ready = 1'b0;
      timeout = 1'b0; saw_ready = 1'b0; stable = 1'b1;
      @(negedge clk);
      start = 1'b1; len = LEN_W'(n); init = init_v; in_valid = 1'b0;
      while (1) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (in_valid && prev_ready) idx++;
         if (out_valid) break;
         if (cyc > 3000) begin timeout = 1'b1; break; end
         prev_ready = in_ready;
         if (in_ready) saw_ready = 1'b1;
         in_valid = (idx < n) && (!gaps || $urandom_range(0, 2) != 0);
         in_x = vx[idx];
         in_y = vy[idx];
         // Stray starts while busy must be ignored.
         if (gaps && busy && $urandom_range(0, 3) == 0) begin
            start = 1'b1; len = 8'd1; init = 16'h1234;
         end
      end
      lat = cyc;
      in_valid = 1'b0;
      start = 1'b0;
      acc = out_acc; ovf = out_ovf; cnt = count;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (out_acc !== acc || out_valid !== 1'b1) stable = 1'b0;
      end
      out_ready = 1'b1;
      if (gaps) begin start = 1'b1; len = 8'd3; init = 16'h0000; end
      @(negedge clk);
      out_ready = 1'b0;
      start = 1'b0;
      dropped_ok = !busy && !out_valid;
      post_acc = out_acc;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({in_ready, out_valid, busy, out_ovf, count, out_acc, core_x, core_y, core_z} !== '0)
         $display("FAIL reset_during: outputs=%h required 0",
                  {in_ready, out_valid, busy, out_ovf, count, out_acc, core_x, core_y, core_z});
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if ({in_ready, out_valid, busy, out_ovf, count, out_acc, core_x, core_y, core_z} !== '0)
         $display("FAIL reset_after: outputs=%h required 0",
                  {in_ready, out_valid, busy, out_ovf, count, out_acc, core_x, core_y, core_z});
      else n_pass++;
   endtask

   task automatic test_basic_sum();
      logic [15:0] acc, pacc; logic ovf; logic [LEN_W-1:0] cnt; int lat; bit to, sr, st, dr;
      for (int i = 0; i < 3; i++) begin vx[i] = 16'h3C00; vy[i] = 16'h3C00; end
      do_run(3, 16'h0000, 1'b0, 0, acc, ovf, cnt, lat, to, sr, st, dr, pacc);
      n_total++;
      if (to || acc !== 16'h4200) $display("FAIL basic_acc: got %h timeout=%0d required 4200", acc, to);
      else n_pass++;
      n_total++;
      if (cnt !== 8'd3 || ovf !== 1'b0) $display("FAIL basic_count_ovf: got %0d/%b required 3/0", cnt, ovf);
      else n_pass++;
      n_total++;
      if (lat != 7) $display("FAIL basic_latency: got %0d required 7", lat);
      else n_pass++;
      n_total++;
      if (pacc !== 16'h4200 || count !== 8'd3 || busy !== 1'b0)
         $display("FAIL basic_after_accept: acc=%h count=%0d busy=%b required 4200/3/0", pacc, count, busy);
      else n_pass++;
   endtask

   task automatic test_mixed_sign();
      logic [15:0] acc, pacc; logic ovf; logic [LEN_W-1:0] cnt; int lat; bit to, sr, st, dr;
      vx[0] = 16'hBC00; vy[0] = 16'h3C00;
      do_run(1, 16'h4200, 1'b0, 0, acc, ovf, cnt, lat, to, sr, st, dr, pacc);
      n_total++;
      if (acc !== 16'h4000) $display("FAIL mixed_first: got %h required 4000", acc);
      else n_pass++;
      vx[0] = 16'h4000; vy[0] = 16'h4200;
      do_run(1, 16'h0000, 1'b0, 0, acc, ovf, cnt, lat, to, sr, st, dr, pacc);
      n_total++;
      if (acc !== 16'h4600 || lat != 3) $display("FAIL mixed_second: got %h lat %0d required 4600 lat 3", acc, lat);
      else n_pass++;
   endtask

   task automatic test_zero_length();
      logic [15:0] acc, pacc; logic ovf; logic [LEN_W-1:0] cnt; int lat; bit to, sr, st, dr;
      do_run(0, 16'h4500, 1'b0, 2, acc, ovf, cnt, lat, to, sr, st, dr, pacc);
      n_total++;
      if (acc !== 16'h4500 || lat != 1 || cnt !== 8'd0)
         $display("FAIL zero_len: acc=%h lat=%0d count=%0d required 4500/1/0", acc, lat, cnt);
      else n_pass++;
      n_total++;
      if (sr) $display("FAIL zero_len_in_ready: in_ready seen=%b required 0", sr);
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [15:0] acc, pacc; logic ovf; logic [LEN_W-1:0] cnt; int lat; bit to, sr, st, dr;
      vx[0] = 16'h7BFF; vy[0] = 16'h7BFF; vx[1] = 16'h3C00; vy[1] = 16'h3C00;
      do_run(2, 16'h0000, 1'b0, 0, acc, ovf, cnt, lat, to, sr, st, dr, pacc);
      n_total++;
      if (ovf !== 1'b1 || acc[14:10] !== 5'h1F)
         $display("FAIL overflow: ovf=%b acc=%h required ovf 1 exponent 1f", ovf, acc);
      else n_pass++;
   endtask

   task automatic test_handshake_stress();
      logic [15:0] acc_a, acc_b, exp_acc, pacc; logic ovf_a, ovf_b, exp_ovf;
      logic [LEN_W-1:0] cnt; int lat; bit to, sr, st, dr;
      int n = 6;
      for (int i = 0; i < n; i++) begin vx[i] = rand_f16(); vy[i] = rand_f16(); end
      model(n, 16'h3800, exp_acc, exp_ovf);
      do_run(n, 16'h3800, 1'b0, 0, acc_a, ovf_a, cnt, lat, to, sr, st, dr, pacc);
      do_run(n, 16'h3800, 1'b1, 5, acc_b, ovf_b, cnt, lat, to, sr, st, dr, pacc);
      n_total++;
      if (to || acc_b !== exp_acc || acc_b !== acc_a)
         $display("FAIL stress_acc: gapped=%h gapfree=%h required %h", acc_b, acc_a, exp_acc);
      else n_pass++;
      n_total++;
      if (cnt !== LEN_W'(n) || ovf_b !== exp_ovf)
         $display("FAIL stress_count_ovf: got %0d/%b required %0d/%b", cnt, ovf_b, n, exp_ovf);
      else n_pass++;
      n_total++;
      if (!st) $display("FAIL stress_hold_stable: stable=%b required 1", st);
      else n_pass++;
      n_total++;
      if (!dr) $display("FAIL stress_start_with_ready: idle=%b required 1", dr);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [15:0] acc, exp_acc, pacc; logic ovf, exp_ovf; logic [LEN_W-1:0] cnt;
      int lat; bit to, sr, st, dr;
      for (int r = 0; r < 4; r++) begin
         int n = $urandom_range(1, 12);
         logic [15:0] iv = rand_f16();
         for (int i = 0; i < n; i++) begin vx[i] = rand_f16(); vy[i] = rand_f16(); end
         model(n, iv, exp_acc, exp_ovf);
         do_run(n, iv, r[0], 1, acc, ovf, cnt, lat, to, sr, st, dr, pacc);
         n_total++;
         if (to || acc !== exp_acc || ovf !== exp_ovf || cnt !== LEN_W'(n))
            $display("FAIL random_run%0d: acc=%h ovf=%b count=%0d required %h/%b/%0d",
                     r, acc, ovf, cnt, exp_acc, exp_ovf, n);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] acc, pacc; logic ovf; logic [LEN_W-1:0] cnt; int lat; bit to, sr, st, dr;
      int k = 0;
      for (int i = 0; i < 4; i++) begin vx[i] = 16'h3C00; vy[i] = 16'h4000; end
      @(negedge clk);
      start = 1'b1; len = 8'd4; init = 16'h0000;
      in_valid = 1'b1; in_x = 16'h3C00; in_y = 16'h4000;
      @(negedge clk);
      start = 1'b0;
      // MAC of pair 2: one pair counted, second pair registered, not ready.
      while (!(busy && !in_ready && count == 8'd1 && k > 2) && k < 50) begin
         @(negedge clk);
         k++;
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (k >= 50 || {in_ready, out_valid, busy, out_ovf, count, out_acc, core_x, core_y, core_z} !== '0)
         $display("FAIL reset_mid_run: outputs=%h waited=%0d required 0",
                  {in_ready, out_valid, busy, out_ovf, count, out_acc, core_x, core_y, core_z}, k);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin vx[i] = 16'h3C00; vy[i] = 16'h3C00; end
      do_run(3, 16'h0000, 1'b0, 0, acc, ovf, cnt, lat, to, sr, st, dr, pacc);
      n_total++;
      if (acc !== 16'h4200 || cnt !== 8'd3 || lat != 7)
         $display("FAIL reset_rerun: acc=%h count=%0d lat=%0d required 4200/3/7", acc, cnt, lat);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_sum();
      test_mixed_sign();
      test_zero_length();
      test_overflow();
      test_handshake_stress();
      test_random();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
